// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller slice: FSM states and size defaults.
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4096;

    // INIT clears the array after reset; RUN serves requesters.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_rr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the priority pointer picks the winner.
// After any grant the pointer moves to the other requester.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] eligible,
    output logic [1:0] grant,
    output logic       ptr
);

    // Grant: a lone eligible requester wins, and a tie goes to the pointer.
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // Pointer: after a grant, point at the requester that did not win.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (grant[0]) begin
            ptr <= 1'b1;
        end else if (grant[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Two-requester front end for a single-port synchronous SRAM. After reset it
// optionally clears the array, then grants at most one access per cycle,
// round-robin between the two requesters. Read data returns two cycles after
// accept.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. The request side offers ready only to the single granted requester
// in that same cycle. On the response side, rsp_valid/rsp_rdata hold stable
// until rsp_ready is seen, and they clear on the following cycle.
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic                init_done,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [DATA_W-1:0]   mem_i,
    output logic                mem_csb,
    output logic                mem_web,
    output logic                mem_oeb,
    input  logic [DATA_W-1:0]   mem_o,
    output state_e              dbg_state,
    output logic                dbg_ptr
);

    localparam state_e             RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] INIT_LAST   = ADDR_W'(DEPTH - 1);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [ADDR_W-1:0] mem_a_q;
    logic [DATA_W-1:0] mem_i_q;
    logic [1:0]        rd_pend;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              run;
    logic              sel_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT once the last address has been cleared.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == INIT_LAST) begin
            state_nxt = ST_RUN;
        end
    end

    // Clear-address counter. It advances only during INIT and wraps back to 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Eligibility: writes always qualify. A read waits until this requester
    // has no read in flight and no response still waiting.
    always_comb begin
        run      = (state == ST_RUN) && !reset;
        eligible = {2{run}} & req_valid & (req_we | ~(rd_pend | rsp_valid));
    end

    rr_arb2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .eligible (eligible),
        .grant    (grant),
        .ptr      (dbg_ptr)
    );

    // Select the fields of the winning request.
    always_comb begin
        sel_idx   = grant[1];
        sel_we    = sel_idx ? req_we[1] : req_we[0];
        sel_addr  = sel_idx ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        sel_wdata = sel_idx ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end

    // FSM outputs: SRAM pins and request ready. All pins go idle while reset is held.
    always_comb begin
        mem_csb   = 1'b1;
        mem_web   = 1'b1;
        mem_oeb   = 1'b1;
        mem_a     = mem_a_q;
        mem_i     = mem_i_q;
        req_ready = 2'b00;
        init_done = 1'b0;
        if (!reset) begin
            case (state)
                ST_INIT: begin
                    mem_csb = 1'b0;
                    mem_web = 1'b0;
                    mem_a   = init_cnt;
                    mem_i   = '0;
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    req_ready = grant;
                    if (|grant) begin
                        mem_csb = 1'b0;
                        mem_web = ~sel_we;
                        mem_oeb = sel_we;
                        mem_a   = sel_addr;
                        if (sel_we) begin
                            mem_i = sel_wdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data pins hold their last driven value across idle cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_a_q <= '0;
            mem_i_q <= '0;
        end else begin
            mem_a_q <= mem_a;
            mem_i_q <= mem_i;
        end
    end

    // Read return: mark the read pending for one cycle, then capture SRAM data
    // into a per-requester response slot that holds until it is consumed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend   <= 2'b00;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rd_pend[i] <= grant[i] & ~req_we[i];
                if (rd_pend[i]) begin
                    rsp_valid[i]                  <= 1'b1;
                    rsp_rdata[i*DATA_W +: DATA_W] <= mem_o;
                end else if (rsp_valid[i] && rsp_ready[i]) begin
                    rsp_valid[i]                  <= 1'b0;
                    rsp_rdata[i*DATA_W +: DATA_W] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter. A behavioural SRAM answers reads one cycle after
// the access. A transaction-level model predicts every output on every cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_sram_rr_arbiter;
    import sram_ctrl_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata, rsp_rdata;
    logic            init_done, mem_csb, mem_web, mem_oeb, dbg_ptr;
    logic [AW-1:0]   mem_a;
    logic [DW-1:0]   mem_i, mem_o;
    state_e          dbg_state;

    sram_rr_arbiter dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .mem_a(mem_a), .mem_i(mem_i),
        .mem_csb(mem_csb), .mem_web(mem_web), .mem_oeb(mem_oeb), .mem_o(mem_o),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    // Second instance with the clear pass disabled.
    logic            r1_reset;
    logic [1:0]      r1_valid, r1_ready, r1_we, r1_rsp_valid, r1_rsp_ready;
    logic [2*AW-1:0] r1_addr;
    logic [2*DW-1:0] r1_wdata, r1_rdata;
    logic            r1_init_done, r1_csb, r1_web, r1_oeb, r1_ptr;
    logic [AW-1:0]   r1_a;
    logic [DW-1:0]   r1_i;
    logic [DW-1:0]   r1_o;
    state_e          r1_state;

    assign r1_o = 8'h3C;

    sram_rr_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_noclr (
        .clock(clock), .reset(r1_reset),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_we(r1_we),
        .req_addr(r1_addr), .req_wdata(r1_wdata),
        .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready), .rsp_rdata(r1_rdata),
        .init_done(r1_init_done), .mem_a(r1_a), .mem_i(r1_i),
        .mem_csb(r1_csb), .mem_web(r1_web), .mem_oeb(r1_oeb), .mem_o(r1_o),
        .dbg_state(r1_state), .dbg_ptr(r1_ptr)
    );

    // ---------------- behavioural SRAM, 1-cycle read latency ----------------
    logic [DW-1:0] sram [4096];
    logic          sram_seeded = 1'b0;
    always @(posedge clock) begin
        if (!sram_seeded) begin
            for (int i = 0; i < 4096; i++) sram[i] <= 8'hEE;
            sram_seeded <= 1'b1;
        end else if (!mem_csb) begin
            if (!mem_web) sram[mem_a] <= mem_i;
            else if (!mem_oeb) mem_o <= sram[mem_a];
        end
    end

    // ---------------- counters and compare helper ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int            who;
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend_q[$];
    logic [DW-1:0] ref_mem [4096];
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd [2];
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_i;
    int            m_cyc;
    bit            m_run;
    bit            m_ptr;
    int            tcyc = 0;

    function automatic bit in_flight(input int who);
        foreach (pend_q[k]) if (pend_q[k].who == who) return 1'b1;
        return 1'b0;
    endfunction

    // Compare process: outputs are checked mid-cycle against the model, then
    // the model advances by one cycle.
    always @(negedge clock) begin
        if (reset) begin
            check("rst_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_init_done", init_done, 0);
            check("rst_pins", {mem_csb, mem_web, mem_oeb}, 3'b111);
            check("rst_mem_a", mem_a, 0);
            check("rst_mem_i", mem_i, 0);
            check("rst_ptr", dbg_ptr, 0);
            m_cyc = 0; m_run = 1'b0; m_ptr = 1'b0;
            exp_rv = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0;
            hold_a = '0; hold_i = '0;
            pend_q.delete();
        end else if (!m_run) begin
            check("init_state", dbg_state, ST_INIT);
            check("init_done_lo", init_done, 0);
            check("init_ready", req_ready, 0);
            check("init_pins", {mem_csb, mem_web, mem_oeb}, 3'b001);
            check("init_mem_a", mem_a, m_cyc);
            check("init_mem_i", mem_i, 0);
            check("init_rsp_valid", rsp_valid, 0);
            ref_mem[m_cyc] = '0;
            hold_a = AW'(m_cyc);
            hold_i = '0;
            m_cyc++;
            if (m_cyc == 4096) m_run = 1'b1;
        end else begin
            logic [1:0]    e;
            logic [1:0]    exp_ready;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            g;
            // Read data becomes visible two cycles after its grant.
            for (int k = pend_q.size() - 1; k >= 0; k--) begin
                if (pend_q[k].due == tcyc) begin
                    exp_rv[pend_q[k].who] = 1'b1;
                    exp_rd[pend_q[k].who] = pend_q[k].data;
                    pend_q.delete(k);
                end
            end
            for (int i = 0; i < 2; i++)
                e[i] = req_valid[i] && (req_we[i] || (!in_flight(i) && !exp_rv[i]));
            g = -1;
            if (e == 2'b11) g = int'(m_ptr);
            else if (e[0]) g = 0;
            else if (e[1]) g = 1;
            exp_ready = (g < 0) ? 2'b00 : (2'b01 << g);
            a = (g < 0) ? hold_a : req_addr[g*AW +: AW];
            d = (g >= 0 && req_we[g]) ? req_wdata[g*DW +: DW] : hold_i;

            check("run_state", dbg_state, ST_RUN);
            check("run_init_done", init_done, 1);
            check("run_ready", req_ready, exp_ready);
            check("run_ptr", dbg_ptr, m_ptr);
            check("run_csb", mem_csb, (g < 0));
            check("run_web", mem_web, !(g >= 0 && req_we[g]));
            check("run_oeb", mem_oeb, !(g >= 0 && !req_we[g]));
            check("run_mem_a", mem_a, a);
            check("run_mem_i", mem_i, d);
            check("run_rsp_valid", rsp_valid, exp_rv);
            check("run_rsp_rdata", rsp_rdata, {exp_rd[1], exp_rd[0]});

            if (g >= 0) begin
                if (req_we[g]) ref_mem[a] = d;
                else pend_q.push_back('{who: g, due: tcyc + 2, data: ref_mem[a]});
                hold_a = a;
                hold_i = d;
                m_ptr  = (g == 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (exp_rv[i] && rsp_ready[i]) begin
                    exp_rv[i] = 1'b0;
                    exp_rd[i] = '0;
                end
            end
        end
        tcyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: run did not complete within time limit");
        summary();
        $finish;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int n_r1;
        logic [1:0] exp_alt [4];
        exp_alt[0] = 2'b01; exp_alt[1] = 2'b10; exp_alt[2] = 2'b01; exp_alt[3] = 2'b10;

        reset = 1'b1; rsp_ready = 2'b11;
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        r1_reset = 1'b1; r1_valid = 2'b00; r1_we = 2'b00; r1_addr = '0;
        r1_wdata = '0; r1_rsp_ready = 2'b11;
        repeat (3) step();

        // Clear pass: init_done rises exactly 4096 cycles after reset release.
        reset = 1'b0;
        n = 0;
        while (!init_done && n < 5000) begin
            step();
            n++;
        end
        check("init_latency", n, 4096);

        // Both requesters write every cycle: grants alternate starting with 0.
        drive(2'b11, 2'b11, 12'h010, 12'h020, 8'h5A, 8'hC3);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_grant", req_ready, exp_alt[k]);
            step();
        end
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        step();

        // Top address reads back as cleared.
        drive(2'b01, 2'b00, 12'hFFF, '0, '0, '0);
        #1;
        check("rd_fff_ready", req_ready, 2'b01);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        step();
        check("rd_fff_valid", rsp_valid, 2'b01);
        check("rd_fff_data", rsp_rdata[7:0], 8'h00);
        step();

        // Write 0xA5 to 0x123, then read it back with latency 2.
        drive(2'b01, 2'b01, 12'h123, '0, 8'hA5, '0);
        step();
        drive(2'b01, 2'b00, 12'h123, '0, '0, '0);
        #1;
        check("wr_rd_ready", req_ready, 2'b01);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        check("wr_rd_lat1", rsp_valid[0], 1'b0);
        step();
        check("wr_rd_lat2", rsp_valid[0], 1'b1);
        check("wr_rd_data", rsp_rdata[7:0], 8'hA5);
        step();

        // Stalled response on requester 0 must not block requester 1.
        rsp_ready = 2'b10;
        drive(2'b01, 2'b00, 12'h010, '0, '0, '0);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        step();
        check("stall_first_valid", rsp_valid[0], 1'b1);
        drive(2'b11, 2'b00, 12'h011, 12'h020, '0, '0);
        n_r1 = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("stall_no_grant0", req_ready[0], 1'b0);
            check("stall_hold_valid", rsp_valid[0], 1'b1);
            check("stall_hold_data", rsp_rdata[7:0], 8'h5A);
            if (rsp_valid[1]) begin
                n_r1++;
                check("stall_r1_data", rsp_rdata[15:8], 8'hC3);
            end
            step();
        end
        check("stall_r1_count", n_r1, 3);
        rsp_ready = 2'b11;
        n = 0;
        #1;
        while (!req_ready[0] && n < 6) begin
            step();
            n++;
        end
        check("stall_release_grant", req_ready[0], 1'b1);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        step();
        check("stall_r0_valid", rsp_valid[0], 1'b1);
        check("stall_r0_data", rsp_rdata[7:0], 8'h00);
        step();
        step();

        // Reset right after a read accept: no response, clear restarts at 0.
        drive(2'b01, 2'b00, 12'h020, '0, '0, '0);
        #1;
        check("rst_rd_ready", req_ready, 2'b01);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        reset = 1'b1;
        #1;
        check("rst_rd_valid", rsp_valid, 2'b00);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rst_restart_addr", mem_a, k);
            check("rst_restart_valid", rsp_valid, 2'b00);
            check("rst_restart_done", init_done, 1'b0);
            step();
        end

        // No clear pass: usable on the very first cycle after reset.
        check("noclr_rst_done", r1_init_done, 1'b0);
        check("noclr_rst_csb", r1_csb, 1'b1);
        r1_valid = 2'b10; r1_we = 2'b10; r1_addr = {12'h055, 12'h000}; r1_wdata = {8'h77, 8'h00};
        r1_reset = 1'b0;
        #1;
        check("noclr_done", r1_init_done, 1'b1);
        check("noclr_ready", r1_ready, 2'b10);
        check("noclr_wr_pins", {r1_csb, r1_web, r1_oeb}, 3'b001);
        step();
        r1_valid = 2'b01; r1_we = 2'b00; r1_addr = {12'h000, 12'h055};
        #1;
        check("noclr_rd_ready", r1_ready, 2'b01);
        check("noclr_rd_pins", {r1_csb, r1_web, r1_oeb}, 3'b010);
        step();
        r1_valid = 2'b00;
        step();
        check("noclr_rsp_valid", r1_rsp_valid, 2'b01);
        check("noclr_rsp_data", r1_rdata[7:0], 8'h3C);

        summary();
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, SRAM address width.
REQ-002 Parameter DATA_W, default 8, SRAM word width.
REQ-003 Parameter DEPTH, default 4096, words cleared during init; SHALL equal 2**ADDR_W.
REQ-004 Parameter CLEAR_ON_RESET, default 1; 0 skips init.
REQ-005 clock  in  1  single clock; the SRAM CE pin SHALL be tied to this same clock at the parent.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-008 req_ready  out  2  request accepted when valid&ready.
REQ-009 req_we  in  2  1 = write, 0 = read.
REQ-010 req_addr  in  2*ADDR_W  requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  2*DATA_W  write data, same slicing.
REQ-012 rsp_valid  out  2  read data valid.
REQ-013 rsp_ready  in  2  read data consumed when valid&ready.
REQ-014 rsp_rdata  out  2*DATA_W  read data, same slicing.
REQ-015 init_done  out  1  high once init clear is complete.
REQ-016 mem_a  out  ADDR_W  to SRAM A.
REQ-017 mem_i  out  DATA_W  to SRAM I.
REQ-018 mem_csb / mem_web / mem_oeb  out  1 each  active-low SRAM chip select, write enable, output enable.
REQ-019 mem_o  in  DATA_W  from SRAM O; valid the cycle after a read access.

Function
REQ-020 FSM states INIT, RUN; reset enters INIT if CLEAR_ON_RESET=1, else RUN.
REQ-021 INIT: one write of zero per cycle at addresses 0..DEPTH-1 ascending; csb=0, web=0, oeb=1; req_ready=0; counter wraps to RUN after DEPTH-1.
REQ-022 init_done=0 in INIT, 1 in RUN, asserted the first RUN cycle.
REQ-023 RUN: at most one access per cycle; SRAM controls are driven combinationally from the granted request in the accept cycle.
REQ-024 Requester i is eligible when req_valid[i]=1 and (req_we[i]=1, or rd_pend[i]=0 and rsp_valid[i]=0).
REQ-025 req_ready[i]=1 only for the single granted requester; ready SHALL NOT depend on req_ready of the other requester.
REQ-026 Arbitration: one eligible requester gets the grant; if both are eligible, the priority pointer picks; after any grant the pointer points to the other requester; pointer resets to 0.
REQ-027 Idle cycle (no grant): csb=1, web=1, oeb=1; mem_a and mem_i hold their previous values.
REQ-028 Write grant: csb=0, web=0, oeb=1, mem_a/mem_i from requester; no response is generated.
REQ-029 Read grant in cycle N: csb=0, web=1, oeb=0; rd_pend[i] set for cycle N+1; mem_o captured into rsp_rdata[i] at end of N+1; rsp_valid[i]=1 from N+2; fixed latency 2.
REQ-030 rsp_valid[i] and rsp_rdata[i] are held stable until rsp_ready[i]=1; they clear the cycle after the handshake.
REQ-031 Responses for the two requesters are independent; one stalled rsp_ready SHALL NOT block the other requester.
REQ-032 A write followed by a read to the same address returns the new data; a read followed by a write returns the old data (strict grant order).

Reset
REQ-033 Async reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rd_pend=0, init_done=0, csb=web=oeb=1, mem_a=0, mem_i=0, init counter=0, pointer=0.
REQ-034 Reset mid-INIT or mid-read restarts INIT and discards in-flight reads without a response.

Structure
REQ-035 Shared package sram_ctrl_pkg SHALL hold the FSM state enum and the ADDR_W/DATA_W/DEPTH defaults.
REQ-036 A single sub-module, rr_arb2 (2-way round-robin grant with pointer), SHALL implement REQ-026.

Verification (use a behavioural SRAM model with 1-cycle read latency)
REQ-037 Reset then idle: init_done rises exactly 4096 cycles after reset deassert; reading 0x0FFF returns 0x00.
REQ-038 Req0 writes 0xA5 to 0x123, then reads 0x123: rsp_valid[0] two cycles after accept with rdata 0xA5.
REQ-039 Both requesters hold valid every cycle with writes: grants alternate 0,1,0,1, starting with 0 after reset.
REQ-040 rsp_ready[0] held low 10 cycles: rsp_rdata[0] stable; req0 reads not granted; req1 reads complete with latency 2.
REQ-041 Reset asserted the cycle after a read accept: no rsp_valid; INIT restarts from address 0.
REQ-042 CLEAR_ON_RESET=0: init_done=1 and req_ready available on the first cycle after reset.
